// File: rtl/turtle_io_port_pkg.sv
// turtle_io_port_pkg: shared constants for the turtle core I/O peripheral
package turtle_io_port_pkg;
    localparam int IO_DATA_W = 16;
    typedef enum logic [1:0] {RF_DIN_ALU, RF_DIN_MEM, RF_DIN_IMM, RF_DIN_IN} rf_din_sel_e;
endpackage

// File: rtl/turtle_io_port_if.sv
// turtle_io_port_if: external TX/RX valid/ready streams of turtle_io_port
interface turtle_io_port_if
    import turtle_io_port_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;
    modport master (input tx_valid, tx_data, rx_ready, output tx_ready, rx_valid, rx_data);
    modport slave (output tx_valid, tx_data, rx_ready, input tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/turtle_io_port_io_fifo.sv
// io_fifo: registered FIFO with wrapping pointers; caller guarantees legal push/pop
module io_fifo
    import turtle_io_port_pkg::*;
#(
    parameter int WIDTH = IO_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign head  = mem[rd_ptr];
    // storage is write-only on push and holds no reset state
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    // pointers wrap naturally; count moves by push minus pop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
endmodule

// File: rtl/turtle_io_port.sv
// turtle_io_port: OUT/IN peripheral with TX/RX FIFOs; TURTLE_IO_STATUS_EN enables sticky status flags
module turtle_io_port
    import turtle_io_port_pkg::*;
#(
    parameter int DATA_W   = IO_DATA_W,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_out_valid,
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic              cpu_in_read,
    output logic [DATA_W-1:0] cpu_in_data,
    output logic              cpu_in_avail,
    input  logic              status_clr,
    output logic              tx_overflow,
    output logic              rx_underflow,
    turtle_io_port_if.slave   io
);
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_head, rx_head;
    logic              tx_push, tx_pop, tx_drop, rx_push, rx_pop, rx_under;
    assign tx_pop   = !tx_empty && io.tx_ready;
    assign tx_push  = cpu_out_valid && (!tx_full || tx_pop);
    assign tx_drop  = cpu_out_valid && !tx_push;
    assign rx_push  = io.rx_valid && !rx_full;
    assign rx_pop   = cpu_in_read && !rx_empty;
    assign rx_under = cpu_in_read && rx_empty;
    assign io.tx_valid   = !tx_empty;
    assign io.tx_data    = tx_head;
    assign io.rx_ready   = !rx_full;
    assign cpu_in_avail  = !rx_empty;
    assign cpu_in_data   = rx_empty ? '0 : rx_head;

    io_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .din(cpu_out_data), .pop(tx_pop),
        .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    io_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .din(io.rx_data), .pop(rx_pop),
        .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

`ifdef TURTLE_IO_STATUS_EN
    // sticky flags: a new event in the same cycle beats a clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
        end else begin
            tx_overflow  <= tx_drop | (tx_overflow & ~status_clr);
            rx_underflow <= rx_under | (rx_underflow & ~status_clr);
        end
`else
    logic unused_status;
    assign unused_status = ^{status_clr, tx_drop, rx_under};
    assign tx_overflow   = 1'b0;
    assign rx_underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_turtle_io_port.sv
// tb_turtle_io_port: scoreboard-based self-checking bench for turtle_io_port
module tb_turtle_io_port;
    localparam int W = 16;
    localparam int TXD = 4;
    localparam int RXD = 4;
`ifdef TURTLE_IO_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_out_valid = 1'b0;
    logic [W-1:0] cpu_out_data = '0;
    logic         cpu_in_read = 1'b0;
    logic [W-1:0] cpu_in_data;
    logic         cpu_in_avail;
    logic         status_clr = 1'b0;
    logic         tx_overflow, rx_underflow;
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] tx_q[$];
    logic [W-1:0] rx_q[$];

    turtle_io_port_if #(.DATA_W(W)) io();

    turtle_io_port #(.DATA_W(W), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_out_valid(cpu_out_valid), .cpu_out_data(cpu_out_data),
        .cpu_in_read(cpu_in_read), .cpu_in_data(cpu_in_data), .cpu_in_avail(cpu_in_avail),
        .status_clr(status_clr), .tx_overflow(tx_overflow), .rx_underflow(rx_underflow),
        .io(io)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        bit tx_full, tx_pop, rx_full, rx_pop;
        tx_full = tx_q.size() == TXD;
        tx_pop  = tx_q.size() > 0 && io.tx_ready;
        rx_full = rx_q.size() == RXD;
        rx_pop  = rx_q.size() > 0 && cpu_in_read;
        if (tx_pop) void'(tx_q.pop_front());
        if (cpu_out_valid && (!tx_full || tx_pop)) tx_q.push_back(cpu_out_data);
        if (rx_pop) void'(rx_q.pop_front());
        if (io.rx_valid && !rx_full) rx_q.push_back(io.rx_data);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cpu_out_valid = 1'b0;
        cpu_in_read = 1'b0;
        status_clr = 1'b0;
        io.tx_ready = 1'b0;
        io.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        io.rx_data = '0;
        rst_n = 1'b0;
        #3;
        checks++; if (io.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", io.tx_valid); end
        checks++; if (io.rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", io.rx_ready); end
        checks++; if (cpu_in_avail !== 1'b0) begin errors++; $display("FAIL reset_in_avail: got %b want 0", cpu_in_avail); end
        checks++; if (cpu_in_data !== 16'h0) begin errors++; $display("FAIL reset_in_data: got %h want 0000", cpu_in_data); end
        checks++; if ({tx_overflow, rx_underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {tx_overflow, rx_underflow}); end
        tx_q.delete();
        rx_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_tx_order();
        cpu_out_valid = 1'b1; cpu_out_data = 16'h1234; tick();
        cpu_out_data = 16'hBEEF; tick();
        cpu_out_valid = 1'b0;
        #1;
        checks++; if (io.tx_data !== 16'h1234) begin errors++; $display("FAIL tx_first_head: got %h want 1234", io.tx_data); end
        tick();
        #1;
        checks++; if (io.tx_data !== 16'h1234) begin errors++; $display("FAIL tx_stall_stable: got %h want 1234", io.tx_data); end
        io.tx_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (io.tx_valid !== 1'b1 || io.tx_data !== tx_q[0]) begin errors++; $display("FAIL tx_order_%0d: got v=%b d=%h want v=1 d=%h", i, io.tx_valid, io.tx_data, tx_q[0]); end
            tick();
        end
        #1;
        checks++; if (io.tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: got %b want 0", io.tx_valid); end
        idle();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            cpu_out_valid = 1'b1; cpu_out_data = W'(16'h0100 + i);
            tick();
        end
        cpu_out_valid = 1'b0;
        #1;
        checks++; if (tx_overflow !== STATUS_EN) begin errors++; $display("FAIL tx_overflow_set: got %b want %b", tx_overflow, STATUS_EN); end
        status_clr = 1'b1; tick(); status_clr = 1'b0;
        #1;
        checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL tx_overflow_clr: got %b want 0", tx_overflow); end
        io.tx_ready = 1'b1;
        for (int i = 0; i < TXD; i++) begin
            #1;
            checks++; if (io.tx_valid !== 1'b1 || io.tx_data !== tx_q[0]) begin errors++; $display("FAIL tx_retained_%0d: got v=%b d=%h want v=1 d=%h", i, io.tx_valid, io.tx_data, tx_q[0]); end
            tick();
        end
        #1;
        checks++; if (io.tx_valid !== 1'b0) begin errors++; $display("FAIL tx_fifth_dropped: got %b want 0", io.tx_valid); end
        idle();
    endtask

    task automatic test_rx_in();
        io.rx_valid = 1'b1; io.rx_data = 16'h00A5;
        tick();
        io.rx_valid = 1'b0;
        #1;
        checks++; if (cpu_in_avail !== 1'b1 || cpu_in_data !== 16'h00A5) begin errors++; $display("FAIL rx_in_head: got a=%b d=%h want a=1 d=00a5", cpu_in_avail, cpu_in_data); end
        cpu_in_read = 1'b1;
        tick();
        cpu_in_read = 1'b0;
        #1;
        checks++; if (cpu_in_avail !== 1'b0 || cpu_in_data !== 16'h0) begin errors++; $display("FAIL rx_in_empty: got a=%b d=%h want a=0 d=0000", cpu_in_avail, cpu_in_data); end
        idle();
    endtask

    task automatic test_underflow();
        cpu_in_read = 1'b1; status_clr = 1'b1;
        #1;
        checks++; if (cpu_in_data !== 16'h0) begin errors++; $display("FAIL underflow_data: got %h want 0000", cpu_in_data); end
        tick();
        idle();
        #1;
        checks++; if (rx_underflow !== STATUS_EN) begin errors++; $display("FAIL underflow_set_beats_clr: got %b want %b", rx_underflow, STATUS_EN); end
        status_clr = 1'b1; tick(); status_clr = 1'b0;
        #1;
        checks++; if (rx_underflow !== 1'b0) begin errors++; $display("FAIL underflow_clr: got %b want 0", rx_underflow); end
    endtask

    task automatic test_rx_full();
        io.rx_valid = 1'b1;
        for (int i = 0; i < RXD + 1; i++) begin
            io.rx_data = W'(16'h3000 + i);
            #1;
            checks++; if (io.rx_ready !== (rx_q.size() < RXD)) begin errors++; $display("FAIL rx_ready_%0d: got %b want %b", i, io.rx_ready, rx_q.size() < RXD); end
            tick();
        end
        cpu_in_read = 1'b1;
        io.rx_data = 16'h3FFF;
        #1;
        checks++; if (io.rx_ready !== 1'b0) begin errors++; $display("FAIL rx_no_push_while_full: got %b want 0", io.rx_ready); end
        tick();
        io.rx_valid = 1'b0;
        for (int i = 0; i < RXD + 1; i++) begin
            #1;
            checks++; if (cpu_in_data !== (rx_q.size() > 0 ? rx_q[0] : 16'h0)) begin errors++; $display("FAIL rx_drain_%0d: got %h want %h", i, cpu_in_data, rx_q.size() > 0 ? rx_q[0] : 16'h0); end
            tick();
        end
        idle();
        io.rx_valid = 1'b1; cpu_in_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            io.rx_data = W'($urandom_range(0, 16'hFFFF));
            #1;
            checks++; if (cpu_in_data !== (rx_q.size() > 0 ? rx_q[0] : 16'h0) || io.rx_ready !== 1'b1) begin errors++; $display("FAIL rx_stream_%0d: got d=%h r=%b want d=%h r=1", i, cpu_in_data, io.rx_ready, rx_q.size() > 0 ? rx_q[0] : 16'h0); end
            tick();
        end
        io.rx_valid = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < TXD; i++) begin
            cpu_out_valid = 1'b1; cpu_out_data = W'(16'h0A00 + i);
            tick();
        end
        cpu_out_data = 16'h0DEF; io.tx_ready = 1'b1;
        #1;
        checks++; if (io.tx_data !== tx_q[0]) begin errors++; $display("FAIL b2b_head: got %h want %h", io.tx_data, tx_q[0]); end
        tick();
        cpu_out_valid = 1'b0; io.tx_ready = 1'b0;
        #1;
        checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_overflow: got %b want 0", tx_overflow); end
        io.tx_ready = 1'b1;
        for (int i = 0; i < TXD; i++) begin
            #1;
            checks++; if (io.tx_valid !== 1'b1 || io.tx_data !== tx_q[0]) begin errors++; $display("FAIL b2b_drain_%0d: got v=%b d=%h want v=1 d=%h", i, io.tx_valid, io.tx_data, tx_q[0]); end
            tick();
        end
        #1;
        checks++; if (io.tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", io.tx_valid); end
        for (int i = 0; i < 8; i++) begin
            cpu_out_valid = 1'b1; cpu_out_data = W'(16'h2000 + i);
            #1;
            if (i > 0) begin
                checks++; if (io.tx_valid !== 1'b1 || io.tx_data !== tx_q[0]) begin errors++; $display("FAIL tx_stream_%0d: got v=%b d=%h want v=1 d=%h", i, io.tx_valid, io.tx_data, tx_q[0]); end
            end
            tick();
        end
        cpu_out_valid = 1'b0;
        #1;
        checks++; if (io.tx_data !== tx_q[0]) begin errors++; $display("FAIL tx_stream_tail: got %h want %h", io.tx_data, tx_q[0]); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        cpu_out_valid = 1'b1; io.rx_valid = 1'b1;
        cpu_out_data = 16'h5A5A; io.rx_data = 16'hC3C3; tick();
        cpu_out_data = 16'h6B6B; io.rx_data = 16'hD4D4; tick();
        idle();
        #1;
        checks++; if (io.tx_valid !== 1'b1 || cpu_in_avail !== 1'b1) begin errors++; $display("FAIL pre_reset_fill: got tv=%b ia=%b want 1 1", io.tx_valid, cpu_in_avail); end
        rst_n = 1'b0;
        #1;
        checks++; if (io.tx_valid !== 1'b0 || cpu_in_avail !== 1'b0 || cpu_in_data !== 16'h0 || io.rx_ready !== 1'b1) begin errors++; $display("FAIL mid_reset: got tv=%b ia=%b d=%h rr=%b want 0 0 0000 1", io.tx_valid, cpu_in_avail, cpu_in_data, io.rx_ready); end
        tx_q.delete();
        rx_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        checks++; if (io.tx_valid !== 1'b0 || cpu_in_avail !== 1'b0) begin errors++; $display("FAIL post_reset: got tv=%b ia=%b want 0 0", io.tx_valid, cpu_in_avail); end
    endtask

    initial begin
        test_reset();
        test_tx_order();
        test_overflow();
        test_rx_in();
        test_underflow();
        test_rx_full();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
